// File: rtl/boot_loader_if.sv
// Boot loader bus bundle: byte-stream receive side, boot RAM write port and
// CPU release/status lines.
//   master : the loader (drives RAM port, rx_ready and status, samples rx_*)
//   slave  : the environment (byte source, boot RAM, CPU reset control)
interface boot_loader_if;
    logic [7:0]  rx_data;    // incoming byte
    logic        rx_valid;   // rx_data is valid
    logic        rx_ready;   // loader accepts a byte this cycle
    logic        ram_cs;     // boot RAM chip select
    logic        ram_oe;     // boot RAM output enable (never used)
    logic [3:0]  ram_we;     // boot RAM byte write enables
    logic [10:0] ram_addr;   // boot RAM byte address, word aligned
    logic [31:0] ram_wdata;  // boot RAM write data
    logic        cpu_hold;   // holds CPU in reset until image verified
    logic        done;       // image loaded, checksum passed
    logic        error;      // bad length or checksum

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, ram_cs, ram_oe, ram_we, ram_addr, ram_wdata,
        output cpu_hold, done, error
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, ram_cs, ram_oe, ram_we, ram_addr, ram_wdata,
        input  cpu_hold, done, error
    );
endinterface

// File: rtl/boot_loader.sv
// Byte-stream boot loader. Receives a frame
//   SYNC_BYTE, LEN_LO, LEN_HI (word count N), 4N payload bytes, CSUM
// packs payload bytes little-endian into 32-bit words, writes them to the boot
// RAM from address 0, verifies (sum(payload) + CSUM) mod 256 == 0 and then
// releases the CPU.
// Ports:
//   clk    : system clock, rising edge
//   rst    : asynchronous active-high reset
//   bus_io : boot_loader_if.master (rx stream in, RAM write port and status out)
module boot_loader #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned MAX_WORDS = 512
) (
    input logic              clk,
    input logic              rst,
    boot_loader_if.master    bus_io
);

    typedef enum logic [2:0] {
        StIdle, StLenLo, StLenHi, StData, StWrite, StCsum, StDone, StError
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  sum_q, sum_d;
    logic [9:0]  word_idx_q, word_idx_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] word_q, word_d;
    logic        ram_cs_q, ram_cs_d;
    logic [3:0]  ram_we_q, ram_we_d;
    logic [10:0] ram_addr_q, ram_addr_d;
    logic [31:0] ram_wdata_q, ram_wdata_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic        rx_ready;
    logic        accept;
    logic [15:0] len_next;
    logic [9:0]  word_idx_inc;
    logic [7:0]  sum_next;

    // Ready is decoded straight from the state register.
    assign rx_ready     = (state_q != StWrite) && (state_q != StDone);
    assign accept       = bus_io.rx_valid && rx_ready;
    assign len_next     = {bus_io.rx_data, len_q[7:0]};
    assign word_idx_inc = word_idx_q + 10'd1;
    assign sum_next     = sum_q + bus_io.rx_data;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        sum_d       = sum_q;
        word_idx_d  = word_idx_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        ram_cs_d    = 1'b0;
        ram_we_d    = 4'b0000;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        done_d      = done_q;
        error_d     = error_q;

        unique case (state_q)
            StIdle, StError: begin
                if (accept && bus_io.rx_data == SYNC_BYTE) begin
                    state_d    = StLenLo;
                    sum_d      = 8'd0;
                    word_idx_d = 10'd0;
                    byte_idx_d = 2'd0;
                    error_d    = 1'b0;
                end
            end
            StLenLo: begin
                if (accept) begin
                    len_d[7:0] = bus_io.rx_data;
                    state_d    = StLenHi;
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_d = len_next;
                    if (len_next == 16'd0 || len_next > 16'(MAX_WORDS)) begin
                        state_d = StError;
                        error_d = 1'b1;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    word_d[{byte_idx_q, 3'b000} +: 8] = bus_io.rx_data;
                    sum_d      = sum_next;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        // Outputs are registered: load the write now so the RAM
                        // strobe is visible for exactly the WRITE cycle.
                        state_d     = StWrite;
                        ram_cs_d    = 1'b1;
                        ram_we_d    = 4'b1111;
                        ram_addr_d  = {word_idx_q[8:0], 2'b00};
                        ram_wdata_d = word_d;
                    end
                end
            end
            StWrite: begin
                word_idx_d = word_idx_inc;
                if ({6'd0, word_idx_inc} == len_q) begin
                    state_d = StCsum;
                end else begin
                    state_d = StData;
                end
            end
            StCsum: begin
                if (accept) begin
                    if (sum_next == 8'd0) begin
                        state_d    = StDone;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d = StError;
                        error_d = 1'b1;
                    end
                end
            end
            StDone: begin
                // Terminal until reset.
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            len_q       <= 16'd0;
            sum_q       <= 8'd0;
            word_idx_q  <= 10'd0;
            byte_idx_q  <= 2'd0;
            word_q      <= 32'd0;
            ram_cs_q    <= 1'b0;
            ram_we_q    <= 4'b0000;
            ram_addr_q  <= 11'd0;
            ram_wdata_q <= 32'd0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            word_idx_q  <= word_idx_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            ram_cs_q    <= ram_cs_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign bus_io.rx_ready  = rx_ready;
    assign bus_io.ram_cs    = ram_cs_q;
    assign bus_io.ram_oe    = 1'b0;
    assign bus_io.ram_we    = ram_we_q;
    assign bus_io.ram_addr  = ram_addr_q;
    assign bus_io.ram_wdata = ram_wdata_q;
    assign bus_io.cpu_hold  = cpu_hold_q;
    assign bus_io.done      = done_q;
    assign bus_io.error     = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: directed frames, expected RAM writes queued when a
// frame is driven and popped by a write monitor.
module tb_boot_loader;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    boot_loader_if bus ();

    boot_loader #(
        .SYNC_BYTE (8'hA5),
        .MAX_WORDS (512)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus.master)
    );

    typedef struct {
        logic [10:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;
    bit          gaps_en = 1'b0;
    logic [10:0] last_addr = 11'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write monitor: every write must match the head of the queue; rx_ready
    // must be low exactly while a write strobe or done is up.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            wr_t w;
            check("ram_oe", 32'(bus.ram_oe), 32'd0);
            check("ram_we", 32'(bus.ram_we), bus.ram_cs ? 32'hF : 32'h0);
            check("rx_ready", 32'(bus.rx_ready), 32'(!(bus.ram_cs || bus.done)));
            if (bus.ram_cs === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(bus.ram_addr), 32'h7FFF_FFFF);
                end else begin
                    w = exp_q.pop_front();
                    check("wr_addr", 32'(bus.ram_addr), 32'(w.addr));
                    check("wr_data", bus.ram_wdata, w.data);
                    last_addr = bus.ram_addr;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int cnt = 0;
        if (gaps_en) begin
            repeat ($urandom_range(0, 2)) begin
                bus.rx_valid = 1'b0;
                bus.rx_data  = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (cnt == 20) check("rx_ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    // kind 0: 11 22 33 .. 88 ; kind 1: (7*i+3) mod 256
    function automatic logic [7:0] pay(input int kind, input int i);
        if (kind == 0) return 8'(8'h11 * (i + 1));
        return 8'(i * 7 + 3);
    endfunction

    task automatic send_frame(input int n, input int kind, input bit bad_csum);
        logic [7:0]  sum = 8'd0;
        logic [31:0] word = 32'd0;
        logic [7:0]  b;
        wr_t         w;
        send_byte(8'hA5);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        for (int i = 0; i < 4 * n; i++) begin
            b = pay(kind, i);
            sum += b;
            word[8 * (i % 4) +: 8] = b;
            if (i % 4 == 3) begin
                w.addr = 11'((i / 4) * 4);
                w.data = word;
                exp_q.push_back(w);
            end
            send_byte(b);
        end
        send_byte(bad_csum ? 8'h00 : 8'(8'd0 - sum));
    endtask

    task automatic check_status(input string tag, input bit d, input bit e, input bit h);
        check({tag, "_done"}, 32'(bus.done), 32'(d));
        check({tag, "_error"}, 32'(bus.error), 32'(e));
        check({tag, "_hold"}, 32'(bus.cpu_hold), 32'(h));
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset(input bit expect_pending);
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        #2;
        check("rst_cs", 32'(bus.ram_cs), 32'd0);
        check("rst_oe", 32'(bus.ram_oe), 32'd0);
        check("rst_we", 32'(bus.ram_we), 32'd0);
        check("rst_addr", 32'(bus.ram_addr), 32'd0);
        check("rst_wdata", bus.ram_wdata, 32'd0);
        check("rst_hold", 32'(bus.cpu_hold), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_error", 32'(bus.error), 32'd0);
        check("rst_ready", 32'(bus.rx_ready), 32'd1);
        if (!expect_pending) check("rst_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    initial begin
        wr_t w;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        #1;
        do_reset(1'b0);

        // Happy path
        send_frame(2, 0, 1'b0);
        check_status("happy", 1'b1, 1'b0, 1'b0);
        check("happy_last_addr", 32'(last_addr), 32'h004);

        // Garbage before sync
        do_reset(1'b0);
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        send_frame(2, 0, 1'b0);
        check_status("garbage", 1'b1, 1'b0, 1'b0);

        // Bad checksum, then recovery from ERROR
        do_reset(1'b0);
        send_frame(2, 0, 1'b1);
        check_status("badcsum", 1'b0, 1'b1, 1'b1);
        send_frame(2, 0, 1'b0);
        check_status("recover", 1'b1, 1'b0, 1'b0);

        // Length bounds
        do_reset(1'b0);
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        check_status("len0", 1'b0, 1'b1, 1'b1);
        send_byte(8'hA5);
        check("len_sync_clears_error", 32'(bus.error), 32'd0);
        send_byte(8'h01);
        send_byte(8'h02);
        check_status("len513", 1'b0, 1'b1, 1'b1);

        do_reset(1'b0);
        send_frame(512, 1, 1'b0);
        check_status("len512", 1'b1, 1'b0, 1'b0);
        check("len512_last_addr", 32'(last_addr), 32'h7FC);

        // Flow control with random valid gaps
        do_reset(1'b0);
        gaps_en = 1'b1;
        send_frame(2, 0, 1'b0);
        check_status("gaps", 1'b1, 1'b0, 1'b0);
        gaps_en = 1'b0;

        // Reset after 6 payload bytes: only the first word may be written
        do_reset(1'b0);
        w.addr = 11'h000;
        w.data = 32'h4433_2211;
        exp_q.push_back(w);
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        for (int i = 0; i < 6; i++) send_byte(pay(0, i));
        check("midrst_first_word", 32'(exp_q.size()), 32'd0);
        do_reset(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_idle_cs", 32'(bus.ram_cs), 32'd0);
        send_frame(2, 0, 1'b0);
        check_status("midrst", 1'b1, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
